// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI configuration register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_reg_pkg;

  // Register map
  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;
  localparam logic [6:0] ADDR_MAX       = 7'h04;

  // Frame geometry; the bit counter saturates one past a full frame to flag overflow
  localparam int         FRAME_BITS = 16;
  localparam logic [4:0] CNT_FULL   = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_OVF    = 5'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

endpackage

// File: rtl/input_sync.sv
// N-flop synchronizer for one asynchronous input bit, resetting to RESET_VAL.
// Latency: STAGES clk cycles from pin to q.
// Backpressure: none; free-running sampler.
module input_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the pin value down the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RESET_VAL}};
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-only slave decoding 16-bit frames into five 8-bit PWM control registers.
// Latency: register update and wr_strobe 4 clk edges after ncs high is first sampled (+1 per extra sync stage).
// Backpressure: none; the controller must honour the SCLK/nCS timing limits.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  logic sclk_s, copi_s, ncs_s;
  logic sclk_d, copi_d, ncs_d;
  logic sclk_rise_q, ncs_rise_q, ncs_fall_q;
  logic [SYNC_STAGES-1:0] warm;
  logic ncs_armed;

  state_t      state;
  logic [15:0] shreg;
  logic [4:0]  bit_cnt;

  input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s));
  input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_s));

  // Edge detection on the synced inputs; copi is delayed to stay aligned with the sclk edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d      <= 1'b0;
      copi_d      <= 1'b0;
      ncs_d       <= 1'b1;
      sclk_rise_q <= 1'b0;
      ncs_rise_q  <= 1'b0;
      ncs_fall_q  <= 1'b0;
    end else begin
      sclk_d      <= sclk_s;
      copi_d      <= copi_s;
      ncs_d       <= ncs_s;
      sclk_rise_q <= sclk_s & ~sclk_d;
      ncs_rise_q  <= ncs_s & ~ncs_d;
      ncs_fall_q  <= ~ncs_s & ncs_d;
    end
  end

  // After reset the synchronizer holds its reset value, not a real pin sample; only arm frame
  // detection once a genuine high nCS has been seen, so an already-low nCS cannot start a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm      <= '0;
      ncs_armed <= 1'b0;
    end else begin
      warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
      ncs_armed <= ncs_armed | (warm[SYNC_STAGES-1] & ncs_s);
    end
  end

  // Frame FSM: collect bits while selected, commit a qualified write after deselect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shreg           <= '0;
      bit_cnt         <= '0;
      wr_strobe       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      wr_strobe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ncs_fall_q && ncs_armed) begin
            shreg   <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Deselect wins over a coincident sclk edge
          if (ncs_rise_q) begin
            state <= COMMIT;
          end else if (sclk_rise_q) begin
            shreg <= {shreg[14:0], copi_d};
            if (bit_cnt != CNT_OVF) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        COMMIT: begin
          if (bit_cnt == CNT_FULL && shreg[15] && shreg[14:8] <= ADDR_MAX) begin
            wr_strobe <= 1'b1;
            case (shreg[14:8])
              ADDR_EN_OUT_LO: en_reg_out_7_0  <= shreg[7:0];
              ADDR_EN_OUT_HI: en_reg_out_15_8 <= shreg[7:0];
              ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shreg[7:0];
              ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shreg[7:0];
              ADDR_DUTY:      pwm_duty_cycle  <= shreg[7:0];
              default: ;
            endcase
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: frames bit-banged at f_clk/8, outputs compared to hand-computed values.
// Latency: checks the commit lands 4 clk edges after nCS high is first sampled.
// Backpressure: n/a.
module tb_spi_reg_bank;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int strobe_first;
  int strobe_width;
  int base_cnt;

  spi_reg_bank #(.SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .wr_strobe      (wr_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally strobe pulses away from the active edge
  always @(negedge clk) if (wr_strobe) strobe_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [7:0] o_lo, input logic [7:0] o_hi,
                          input logic [7:0] p_lo, input logic [7:0] p_hi, input logic [7:0] duty);
    chk({tag, ".en_out_lo"}, 32'(en_reg_out_7_0), 32'(o_lo));
    chk({tag, ".en_out_hi"}, 32'(en_reg_out_15_8), 32'(o_hi));
    chk({tag, ".en_pwm_lo"}, 32'(en_reg_pwm_7_0), 32'(p_lo));
    chk({tag, ".en_pwm_hi"}, 32'(en_reg_pwm_15_8), 32'(p_hi));
    chk({tag, ".duty"}, 32'(pwm_duty_cycle), 32'(duty));
  endtask

  // Clock out n bits MSB first, SCLK 4 clk low / 4 clk high; nCS untouched
  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    @(negedge clk);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(v, n);
    repeat (4) @(negedge clk);
  endtask

  // Raise nCS and record when (negedge index after the first sampling edge) and how long wr_strobe is high
  task automatic end_frame();
    ncs = 1'b1;
    strobe_first = -1;
    strobe_width = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (wr_strobe) begin
        if (strobe_first < 0) strobe_first = k;
        strobe_width++;
      end
    end
  endtask

  task automatic frame(input logic [31:0] v, input int n);
    send_bits(v, n);
    end_frame();
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    repeat (3) @(negedge clk);
    chk_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset.strobe", 32'(wr_strobe), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Single write to duty cycle, with latency and pulse width
    frame(32'h8480, 16);
    chk("single.latency", 32'(strobe_first), 32'd4);
    chk("single.width", 32'(strobe_width), 32'd1);
    chk_regs("single", 8'h00, 8'h00, 8'h00, 8'h00, 8'h80);
    chk("single.strobes", 32'(strobe_cnt), 32'd1);

    // Five back-to-back writes
    base_cnt = strobe_cnt;
    frame(32'h80A5, 16);
    frame(32'h815A, 16);
    frame(32'h82FF, 16);
    frame(32'h8301, 16);
    frame(32'h843C, 16);
    chk_regs("b2b", 8'hA5, 8'h5A, 8'hFF, 8'h01, 8'h3C);
    chk("b2b.strobes", 32'(strobe_cnt - base_cnt), 32'd5);

    // Rejected frames with duty preset to 0x80
    frame(32'h8480, 16);
    chk("preset.duty", 32'(pwm_duty_cycle), 32'h80);
    base_cnt = strobe_cnt;
    frame(32'h0455, 16);
    chk("read.duty", 32'(pwm_duty_cycle), 32'h80);
    chk("read.strobes", 32'(strobe_cnt - base_cnt), 32'd0);
    frame(32'h8511, 16);
    chk("addr5.duty", 32'(pwm_duty_cycle), 32'h80);
    chk("addr5.strobes", 32'(strobe_cnt - base_cnt), 32'd0);
    frame(32'h8477 >> 1, 15);
    chk("short.duty", 32'(pwm_duty_cycle), 32'h80);
    chk("short.strobes", 32'(strobe_cnt - base_cnt), 32'd0);
    frame({15'd0, 16'h8477, 1'b1}, 17);
    chk("long.duty", 32'(pwm_duty_cycle), 32'h80);
    chk("long.strobes", 32'(strobe_cnt - base_cnt), 32'd0);
    chk_regs("rejects", 8'hA5, 8'h5A, 8'hFF, 8'h01, 8'h80);

    // Aborted 8-bit frame then a good one
    base_cnt = strobe_cnt;
    frame(32'h82, 8);
    chk("abort.strobes", 32'(strobe_cnt - base_cnt), 32'd0);
    frame(32'h8233, 16);
    chk_regs("abort", 8'hA5, 8'h5A, 8'h33, 8'h01, 8'h80);
    chk("abort.strobes2", 32'(strobe_cnt - base_cnt), 32'd1);

    // Reset after 10 bits with nCS held low; outputs clear without a clock edge
    send_bits(32'h8477 >> 6, 10);
    rst_n = 1'b0;
    #1;
    chk_regs("arst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("arst.strobe", 32'(wr_strobe), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // A full frame clocked while nCS stays low since reset must not be taken
    base_cnt = strobe_cnt;
    shift_bits(32'h8199, 16);
    repeat (4) @(negedge clk);
    end_frame();
    chk("stale_ncs.strobes", 32'(strobe_cnt - base_cnt), 32'd0);
    chk("stale_ncs.en_out_hi", 32'(en_reg_out_15_8), 32'h00);

    frame(32'h8012, 16);
    chk_regs("post_rst", 8'h12, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("post_rst.strobes", 32'(strobe_cnt - base_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

SPI-slave (mode 0, write-only) configuration register bank that sits directly upstream of `pwm_peripheral` in the `tt_um_uwasic_onboarding_gong` top level. It decodes 16-bit frames from an external controller and drives the five 8-bit control registers the PWM block consumes: output enables, PWM enables and duty cycle. It runs entirely in the `clk` domain and oversamples SCLK, COPI and nCS through synchronizers.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchronizer; legal values are 2 or 3.
- `clk` input, 1 bit: system clock; the only clock in the block.
- `rst_n` input, 1 bit: reset, asynchronous and active-low. Clears all state.
- `sclk` input, 1 bit: SPI clock, asynchronous. Top-level wiring is `ui_in[0]`.
- `copi` input, 1 bit: SPI data in, asynchronous. Top-level wiring is `ui_in[1]`.
- `ncs` input, 1 bit: SPI chip select, active-low, asynchronous. Top-level wiring is `ui_in[2]`.
- `en_reg_out_7_0` output, 8 bits: register at address 0x00.
- `en_reg_out_15_8` output, 8 bits: register at address 0x01.
- `en_reg_pwm_7_0` output, 8 bits: register at address 0x02.
- `en_reg_pwm_15_8` output, 8 bits: register at address 0x03.
- `pwm_duty_cycle` output, 8 bits: register at address 0x04.
- `wr_strobe` output, 1 bit: one-cycle pulse on every committed register write.

## Operation
- **Synchronization:** each of `sclk`, `copi` and `ncs` passes through `SYNC_STAGES` flip-flops. A further register on the synced `sclk` and `ncs` provides edge detection.
- **Frame format:** MSB first, exactly 16 bits.
  - bit15 is R/W, where 1 = write.
  - bits14:8 are the 7-bit address.
  - bits7:0 are the data.
- **Sampling:** COPI is sampled on a synced SCLK rising edge while synced nCS is low. SCLK falling edges are ignored.
- **FSM states:**
  - IDLE: on a synced nCS falling edge, clear the shift register and the bit count, then go to SHIFT.
  - SHIFT: on each SCLK rise, shift in COPI and increment the 5-bit bit count. The count saturates at 17, which marks overflow. On a synced nCS rising edge, go to COMMIT.
  - COMMIT: lasts one cycle. The write is performed only if all of these hold: bit count == 16, bit15 == 1, and address ≤ 0x04. In that case, write the data to the addressed register and pulse `wr_strobe`. In every case, return to IDLE.
- **Discarded frames (no write, no strobe):**
  - Read frames (bit15 = 0).
  - Addresses 0x05–0x7F.
  - Short frames (<16 bits).
  - Long frames (>16 bits).
- **Simultaneous SCLK rise and nCS rise in the same synced cycle:** the nCS rise takes priority and that SCLK edge is not counted.
- **Register behaviour:** registers hold their value between writes. Outputs are driven directly from the registers, with no combinational path from any input.
- **Reset:** all five registers = 0x00, `wr_strobe` = 0, FSM = IDLE, shift register and count = 0. Asserting reset mid-frame aborts the frame. After reset is released, an already-low nCS does not start a frame; a fresh nCS falling edge is required.

## Timing
- **Commit latency:** with `SYNC_STAGES`=2, the register update and `wr_strobe` occur on the 4th `clk` rising edge after the `clk` edge that first samples `ncs` high at the pin. Latency grows by 1 per extra sync stage.
- **`wr_strobe` width:** high for exactly 1 cycle, coincident with the cycle in which the new register value first appears.
- **SCLK high and low times:** each must be ≥ (`SYNC_STAGES`+1) `clk` periods. This gives f_SCLK ≤ f_clk/6 for 2 stages.
- **COPI:** must be stable ≥ 1 `clk` period before and after each SCLK rise at the pin.
- **nCS high time between frames:** ≥ `SYNC_STAGES`+2 `clk` periods, so that COMMIT and IDLE are observed.
- **Back-to-back frames** meeting these limits are all committed, in order.

## Structure
- **Package `spi_reg_pkg`** holds:
  - Address constants: `ADDR_EN_OUT_LO`=0x00, `ADDR_EN_OUT_HI`=0x01, `ADDR_EN_PWM_LO`=0x02, `ADDR_EN_PWM_HI`=0x03, `ADDR_DUTY`=0x04, `ADDR_MAX`=0x04.
  - `FRAME_BITS`=16.
  - The FSM state enum: IDLE, SHIFT, COMMIT.
- **Sub-module `input_sync`** is a parameterised N-flop synchronizer with async active-low reset to 0. It is instantiated three times. For `ncs`, the reset value is 1, set via the module's `RESET_VAL` parameter.
- **Top-level change:** the top level instantiates `spi_reg_bank` and connects its five register outputs to the existing wires feeding `pwm_peripheral`. `ui_in[2:0]` are removed from the unused list.

## Test plan
- **Reset:** assert `rst_n`=0 mid-operation → all five outputs 0x00 and `wr_strobe`=0, with no clock required.
- **Single write:** frame 0x8480 (write, addr 0x04, data 0x80) at f_clk/8 → `pwm_duty_cycle`=0x80 and one `wr_strobe` pulse 4 cycles after the nCS rise; other registers remain 0x00.
- **Five back-to-back writes:** data 0xA5, 0x5A, 0xFF, 0x01, 0x3C to addresses 0x00–0x04 → each register holds its value and there are exactly 5 strobes.
- **Rejected frames, each after `pwm_duty_cycle` has been set to 0x80:**
  - Read frame 0x0455 → no change, no strobe.
  - Address 0x05 (frame 0x8511) → no change, no strobe.
  - 15-bit frame → no change, no strobe.
  - 17-bit frame → no change, no strobe.
- **Abort:** nCS raised after 8 bits, then a full frame 0x8233 → only `en_reg_pwm_7_0`=0x33 updates.
- **Reset mid-frame:** reset pulsed after 10 bits with nCS held low, then nCS raised and lowered and frame 0x8012 sent → `en_reg_out_7_0`=0x12, and nothing else changes from 0x00.
